// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op codes and default datapath widths for the
//               issue stage and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DW   = 8;
    localparam int ALU_NREG = 4;
    localparam int ALU_AW   = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_INC = 3'b001,
        OP_SUB = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_NOT = 3'b110,
        OP_SHL = 3'b111
    } alu_op_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : General register array, one write port and two
//               combinational read ports, synchronously cleared on rst.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule : regfile
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Register-read / issue stage with per-register pending
//               scoreboard and a one-deep output bundle toward the ALU.
//               Optional macro ALU_ISSUE_BYPASS_EN forwards same-cycle
//               write-back data to the read ports and removes that stall.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
#(
    parameter  int DW   = ALU_DW,
    parameter  int NREG = ALU_NREG,
    localparam int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_alus,
    output logic [DW-1:0] out_x,
    output logic [DW-1:0] out_bus,
    output logic [AW-1:0] out_rd,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data
);

`ifdef ALU_ISSUE_BYPASS_EN
    localparam logic c_BYPASS = 1'b1;
`else
    localparam logic c_BYPASS = 1'b0;
`endif

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_next;
    logic [NREG-1:0] w_haz;
    logic            w_hazard;
    logic            w_accept;
    logic            w_fwd_x;
    logic            w_fwd_bus;
    logic [DW-1:0]   w_rd_x;
    logic [DW-1:0]   w_rd_bus;
    logic [DW-1:0]   w_x;
    logic [DW-1:0]   w_bus;

    logic            r_out_valid;
    logic [2:0]      r_out_alus;
    logic [DW-1:0]   r_out_x;
    logic [DW-1:0]   r_out_bus;
    logic [AW-1:0]   r_out_rd;

    regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (in_rs),
        .o_rdata_a (w_rd_x),
        .i_raddr_b (in_rd),
        .o_rdata_b (w_rd_bus)
    );

    // A pending register is released early only when its write-back can be forwarded.
    always_comb begin
        w_haz = '0;
        for (int i = 0; i < NREG; i++) begin
            w_haz[i] = r_pend[i] & ~(c_BYPASS & wb_en & (wb_addr == AW'(i)));
        end
    end

    assign w_hazard  = w_haz[in_rs] | w_haz[in_rd];
    assign in_ready  = (~r_out_valid | out_ready) & ~w_hazard;
    assign w_accept  = in_valid & in_ready;

    assign w_fwd_x   = c_BYPASS & wb_en & (wb_addr == in_rs);
    assign w_fwd_bus = c_BYPASS & wb_en & (wb_addr == in_rd);
    assign w_x       = w_fwd_x   ? wb_data : w_rd_x;
    assign w_bus     = w_fwd_bus ? wb_data : w_rd_bus;

    // Accept is applied after write-back so a same-index set takes priority.
    always_comb begin
        w_pend_next = r_pend;
        if (wb_en) begin
            w_pend_next[wb_addr] = 1'b0;
        end
        if (w_accept) begin
            w_pend_next[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_alus  <= '0;
            r_out_x     <= '0;
            r_out_bus   <= '0;
            r_out_rd    <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_alus  <= in_op;
                r_out_x     <= w_x;
                r_out_bus   <= w_bus;
                r_out_rd    <= in_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_alus  = r_out_alus;
    assign out_x     = r_out_x;
    assign out_bus   = r_out_bus;
    assign out_rd    = r_out_rd;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Table-driven self-checking bench for alu_issue, plus a
//               hand sequence for the write-back release of a hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;
    import alu_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [1:0] in_rs;
    logic [1:0] in_rd;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_alus;
    logic [7:0] out_x;
    logic [7:0] out_bus;
    logic [1:0] out_rd;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue #(.DW(8), .NREG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_alus  (out_alus),
        .out_x     (out_x),
        .out_bus   (out_bus),
        .out_rd    (out_rd),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    typedef struct {
        logic       rst;
        logic       wen;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       iv;
        logic [2:0] op;
        logic [1:0] rs;
        logic [1:0] rd;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic [2:0] e_alus;
        logic [7:0] e_x;
        logic [7:0] e_bus;
        logic [1:0] e_rd;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic wen, logic [1:0] wa, logic [7:0] wd,
                                logic iv, logic [2:0] op, logic [1:0] rs, logic [1:0] rd,
                                logic ordy, logic e_rdy, logic e_ov, logic [2:0] e_alus,
                                logic [7:0] e_x, logic [7:0] e_bus, logic [1:0] e_rd);
        vec_t v;
        v.rst = r;    v.wen = wen;   v.wa = wa;       v.wd = wd;
        v.iv = iv;    v.op = op;     v.rs = rs;       v.rd = rd;
        v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_alus = e_alus;
        v.e_x = e_x;  v.e_bus = e_bus; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;  wb_en = v.wen; wb_addr = v.wa; wb_data = v.wd;
        in_valid = v.iv; in_op = v.op; in_rs = v.rs; in_rd = v.rd;
        out_ready = v.ordy;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk("in_ready", idx, int'(in_ready), int'(v.e_rdy));
        @(posedge clk);
        #1;
        chk("out_valid", idx, int'(out_valid), int'(v.e_ov));
        chk("out_alus",  idx, int'(out_alus),  int'(v.e_alus));
        chk("out_x",     idx, int'(out_x),     int'(v.e_x));
        chk("out_bus",   idx, int'(out_bus),   int'(v.e_bus));
        chk("out_rd",    idx, int'(out_rd),    int'(v.e_rd));
    endtask

    localparam logic [7:0] X16 = BYP ? 8'h33 : 8'h22;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int acc_at;

        //        rst wen wa wd     iv op      rs rd ordy rdy ov alus x      bus    rd
        tbl[0]  = mk(0, 0, 0, 8'h00, 1, OP_ADD, 1, 2, 0,  1,  1, 0, 8'h00, 8'h00, 2);
        tbl[1]  = mk(0, 0, 0, 8'h00, 0, OP_ADD, 2, 0, 0,  0,  1, 0, 8'h00, 8'h00, 2);
        tbl[2]  = mk(0, 0, 0, 8'h00, 0, OP_ADD, 1, 0, 1,  1,  0, 0, 8'h00, 8'h00, 2);
        tbl[3]  = mk(0, 1, 1, 8'h05, 0, OP_ADD, 0, 0, 1,  1,  0, 0, 8'h00, 8'h00, 2);
        tbl[4]  = mk(0, 1, 2, 8'h03, 0, OP_ADD, 0, 0, 1,  1,  0, 0, 8'h00, 8'h00, 2);
        tbl[5]  = mk(0, 0, 0, 8'h00, 1, OP_SUB, 1, 2, 1,  1,  1, 2, 8'h05, 8'h03, 2);
        tbl[6]  = mk(0, 0, 0, 8'h00, 1, OP_OR,  1, 0, 1,  1,  1, 5, 8'h05, 8'h00, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 1, OP_NOT, 1, 1, 1,  1,  1, 6, 8'h05, 8'h05, 1);
        tbl[8]  = mk(0, 0, 0, 8'h00, 1, OP_SHL, 0, 3, 1,  0,  0, 6, 8'h05, 8'h05, 1);
        tbl[9]  = mk(0, 1, 0, 8'h11, 0, OP_SHL, 3, 3, 1,  1,  0, 6, 8'h05, 8'h05, 1);
        tbl[10] = mk(0, 0, 0, 8'h00, 1, OP_SHL, 0, 3, 0,  1,  1, 7, 8'h11, 8'h00, 3);
        tbl[11] = mk(0, 0, 0, 8'h00, 1, OP_ADD, 0, 0, 0,  0,  1, 7, 8'h11, 8'h00, 3);
        tbl[12] = mk(0, 0, 0, 8'h00, 1, OP_ADD, 0, 0, 0,  0,  1, 7, 8'h11, 8'h00, 3);
        tbl[13] = mk(0, 0, 0, 8'h00, 1, OP_ADD, 0, 0, 0,  0,  1, 7, 8'h11, 8'h00, 3);
        tbl[14] = mk(0, 0, 0, 8'h00, 1, OP_ADD, 0, 0, 1,  1,  1, 0, 8'h11, 8'h11, 0);
        tbl[15] = mk(0, 1, 1, 8'h22, 0, OP_ADD, 0, 0, 1,  0,  0, 0, 8'h11, 8'h11, 0);
        tbl[16] = mk(0, 1, 1, 8'h33, 1, OP_AND, 1, 1, 1,  1,  1, 4, X16,   X16,   1);
        tbl[17] = mk(0, 0, 0, 8'h00, 0, OP_AND, 1, 1, 1,  0,  0, 4, X16,   X16,   1);
        tbl[18] = mk(0, 1, 3, 8'h55, 0, OP_ADD, 0, 0, 1,  0,  0, 4, X16,   X16,   1);
        tbl[19] = mk(0, 0, 0, 8'h00, 1, OP_OR,  3, 3, 0,  1,  1, 5, 8'h55, 8'h55, 3);
        tbl[20] = mk(1, 1, 1, 8'h77, 1, OP_ADD, 0, 0, 0,  0,  0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            tbl[21+i] = mk(0, 0, 0, 8'h00, 1, OP_ADD, 2'(i), 2'(i), 1, 1, 1, 0, 8'h00, 8'h00, 2'(i));
        end

        rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rd = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 0, int'(out_valid), 0);
        chk("rst_out_alus",  0, int'(out_alus),  0);
        chk("rst_out_x",     0, int'(out_x),     0);
        chk("rst_out_bus",   0, int'(out_bus),   0);
        chk("rst_out_rd",    0, int'(out_rd),    0);
        chk("rst_in_ready",  0, int'(in_ready),  1);

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], i);
        end

        // Hazard on source released by write-back of that register.
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1; in_op = OP_INC; in_rs = 2'd0; in_rd = 2'd3;
        #1;
        chk("h_inc_ready", 0, int'(in_ready), 1);
        @(negedge clk);
        in_op = OP_AND; in_rs = 2'd3; in_rd = 2'd1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("h_stall_ready", c, int'(in_ready), 0);
            @(negedge clk);
        end
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h2A;
        acc_at = -1;
        k = 0;
        while (k < 5 && acc_at < 0) begin
            #1;
            if (in_ready) acc_at = k;
            @(posedge clk);
            #1;
            if (acc_at < 0) begin
                @(negedge clk);
                wb_en = 1'b0;
            end
            k++;
        end
        chk("h_accept_cycle", 0, acc_at, BYP ? 0 : 1);
        chk("h_out_valid", 0, int'(out_valid), 1);
        chk("h_out_x",     0, int'(out_x),     8'h2A);
        chk("h_out_bus",   0, int'(out_bus),   8'h00);
        chk("h_out_alus",  0, int'(out_alus),  int'(OP_AND));
        chk("h_out_rd",    0, int'(out_rd),    1);
        @(negedge clk);
        in_valid = 1'b0; wb_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_alu_issue
`default_nettype wire
